// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: dm access-type codes and arbiter state.
package dm_arbiter_pkg;

  localparam logic [2:0] DM_WORD              = 3'd0;
  localparam logic [2:0] DM_HALFWORD          = 3'd1;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;
  localparam logic [2:0] DM_BYTE              = 3'd3;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'd4;

  typedef enum logic {
    ARB_CPU_OWN   = 1'b0,
    ARB_DBG_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Counts consecutive denied DBG cycles; hit_o fires on the denial that reaches the limit.
module dm_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [7:0] LastCnt = 8'(STARVE_LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign hit_o = inc_i & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || hit_o) begin
      cnt_d = 8'd0;
    end else if (inc_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (priority) and a debug port,
// with a starvation-forced DBG slot and registered DBG read return.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned DM_WORDS     = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [2:0]  cpu_type_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [2:0]  dbg_type_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic        dm_wr_o,
  output logic [2:0]  dm_type_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_din_o,
  input  logic [31:0] dm_dout_i
);

  localparam logic [31:0] DmBytes = 32'(DM_WORDS * 4);

  arb_state_e  state_q, state_d;
  logic        force_st, dbg_own, dbg_oor, denied, starve_hit;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  assign force_st = (state_q == ARB_DBG_FORCE);
  // A forced slot with no DBG request leaves the CPU in charge (no grant, no stall).
  assign dbg_own  = dbg_req_i & (force_st | ~cpu_req_i);
  assign dbg_oor  = (dbg_addr_i >= DmBytes);
  assign denied   = ~force_st & cpu_req_i & dbg_req_i;

  dm_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (dbg_own | ~dbg_req_i),
    .inc_i (denied),
    .hit_o (starve_hit)
  );

  always_comb begin
    dm_wr_o     = cpu_req_i & cpu_we_i;
    dm_type_o   = cpu_type_i;
    dm_addr_o   = cpu_addr_i;
    dm_din_o    = cpu_wdata_i;
    dbg_gnt_o   = 1'b0;
    cpu_stall_o = 1'b0;
    if (dbg_own) begin
      dm_wr_o     = dbg_we_i & ~dbg_oor;
      dm_type_o   = dbg_type_i;
      dm_addr_o   = dbg_addr_i;
      dm_din_o    = dbg_wdata_i;
      dbg_gnt_o   = 1'b1;
      cpu_stall_o = force_st & cpu_req_i;
    end
  end

  assign cpu_rdata_o = dm_dout_i;

  always_comb begin
    state_d = starve_hit ? ARB_DBG_FORCE : ARB_CPU_OWN;
  end

  // Reads and out-of-range accesses of either kind report back the following cycle.
  always_comb begin
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (dbg_own && (!dbg_we_i || dbg_oor)) begin
      rvalid_d = 1'b1;
      err_d    = dbg_oor;
      rdata_d  = dbg_oor ? 32'd0 : dm_dout_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_CPU_OWN;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbg_rvalid_o = rvalid_q;
  assign dbg_err_o    = err_q;
  assign dbg_rdata_o  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int unsigned LIMIT = 8;
  localparam logic [31:0] DM_BYTES = 32'd512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_type = DM_WORD;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [2:0]  dbg_type = DM_WORD;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
  logic        dbg_gnt, dbg_rvalid, dbg_err;
  logic        dm_wr;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr, dm_din, dm_dout;

  logic [31:0] mem [128];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: forced-slot flag, denial run length, pending read return.
  bit          m_force = 1'b0;
  int          m_wait  = 0;
  bit          m_rvalid = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          gnt_seen = 1'b0;

  always #5 clk = ~clk;

  dm_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .DM_WORDS     (128)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_type_i   (cpu_type),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .dbg_req_i    (dbg_req),
    .dbg_we_i     (dbg_we),
    .dbg_type_i   (dbg_type),
    .dbg_addr_i   (dbg_addr),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_gnt_o    (dbg_gnt),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .dbg_err_o    (dbg_err),
    .dm_wr_o      (dm_wr),
    .dm_type_o    (dm_type),
    .dm_addr_o    (dm_addr),
    .dm_din_o     (dm_din),
    .dm_dout_i    (dm_dout)
  );

  assign dm_dout = mem[dm_addr[8:2]];

  always @(posedge clk) begin
    if (dm_wr) mem[dm_addr[8:2]] <= dm_din;
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Compare against the model every cycle, then advance it past the coming posedge.
  always @(negedge clk) begin
    bit e_dbg, oor, denied, nf;
    if (rst) begin
      m_force = 1'b0; m_wait = 0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
      chk1("rst_rvalid", dbg_rvalid, 1'b0);
      chk1("rst_gnt", dbg_gnt, dbg_req && !cpu_req);
      chk1("rst_stall", cpu_stall, 1'b0);
    end else begin
      e_dbg = dbg_req && (m_force || !cpu_req);
      oor   = (dbg_addr >= DM_BYTES);
      chk1("m_gnt", dbg_gnt, e_dbg);
      chk1("m_stall", cpu_stall, m_force && dbg_req && cpu_req);
      chk1("m_dm_wr", dm_wr, e_dbg ? (dbg_we && !oor) : (cpu_req && cpu_we));
      chk32("m_dm_addr", dm_addr, e_dbg ? dbg_addr : cpu_addr);
      chk32("m_dm_type", 32'(dm_type), 32'(e_dbg ? dbg_type : cpu_type));
      chk32("m_dm_din", dm_din, e_dbg ? dbg_wdata : cpu_wdata);
      chk1("m_rvalid", dbg_rvalid, m_rvalid);
      chk1("m_err", dbg_err, m_err);
      chk32("m_rdata", dbg_rdata, m_rdata);
      if (cpu_req && !e_dbg) chk32("m_cpu_rdata", cpu_rdata, mem[cpu_addr[8:2]]);

      if (e_dbg && (!dbg_we || oor)) begin
        m_rvalid = 1'b1;
        m_err    = oor;
        m_rdata  = oor ? 32'd0 : mem[dbg_addr[8:2]];
      end else begin
        m_rvalid = 1'b0;
        m_err    = 1'b0;
      end
      denied = !m_force && cpu_req && dbg_req;
      nf = 1'b0;
      if (denied) begin
        m_wait++;
        if (m_wait == int'(LIMIT)) begin
          nf = 1'b1;
          m_wait = 0;
        end
      end else begin
        m_wait = 0;
      end
      m_force = nf;
    end
    gnt_seen = dbg_gnt;
  end

  initial begin
    logic [31:0] w0;
    int unsigned r;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i) * 32'h01010101;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk1("reset_rvalid", dbg_rvalid, 1'b0);
    chk32("reset_rdata", dbg_rdata, 32'd0);

    // DBG alone: write then read back
    nxt();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF; dbg_type = DM_WORD;
    smp(); chk1("alone_wr_gnt", dbg_gnt, 1'b1); chk1("alone_wr_dmwr", dm_wr, 1'b1);
    nxt();
    dbg_we = 0;
    smp(); chk1("alone_rd_gnt", dbg_gnt, 1'b1); chk1("alone_rd_dmwr", dm_wr, 1'b0);
    nxt();
    dbg_req = 0;
    smp();
    chk1("alone_rvalid", dbg_rvalid, 1'b1);
    chk32("alone_rdata", dbg_rdata, 32'hDEADBEEF);
    chk1("alone_err", dbg_err, 1'b0);

    // CPU priority with forced slot on cycle 9
    mem[8] = 32'h12345678;
    nxt();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk1("prio_stall", cpu_stall, 1'b0);
      chk32("prio_rdata", cpu_rdata, 32'h12345678);
      nxt();
    end
    smp(); chk1("prio_force_stall", cpu_stall, 1'b1); chk1("prio_force_gnt", dbg_gnt, 1'b1);
    nxt();
    dbg_req = 0;
    smp(); chk1("prio_after_stall", cpu_stall, 1'b0);

    // Forced-slot write isolation
    nxt();
    cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h0000AAAA;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'h00005555;
    for (int i = 0; i < 8; i++) begin
      smp();
      nxt();
    end
    smp();
    chk1("iso_dmwr", dm_wr, 1'b1);
    chk32("iso_din", dm_din, 32'h00005555);
    chk1("iso_stall", cpu_stall, 1'b1);
    nxt();
    dbg_req = 0;
    smp();
    chk32("iso_mem_dbg", mem[12], 32'h00005555);
    chk32("iso_cpu_din", dm_din, 32'h0000AAAA);
    nxt();
    cpu_req = 0; cpu_we = 0;
    smp(); chk32("iso_mem_final", mem[12], 32'h0000AAAA);

    // Out-of-range DBG write
    w0 = mem[0];
    nxt();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h200; dbg_wdata = 32'hFFFFFFFF;
    smp(); chk1("oor_gnt", dbg_gnt, 1'b1); chk1("oor_dmwr", dm_wr, 1'b0);
    nxt();
    dbg_req = 0;
    smp();
    chk1("oor_rvalid", dbg_rvalid, 1'b1);
    chk1("oor_err", dbg_err, 1'b1);
    chk32("oor_rdata", dbg_rdata, 32'd0);
    chk32("oor_mem", mem[0], w0);

    // Back-to-back reads
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
    nxt();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0;
    smp(); chk1("b2b_gnt0", dbg_gnt, 1'b1);
    nxt(); dbg_addr = 32'h4;
    smp(); chk1("b2b_gnt1", dbg_gnt, 1'b1); chk32("b2b_d0", dbg_rdata, 32'h11111111);
    nxt(); dbg_addr = 32'h8;
    smp(); chk1("b2b_gnt2", dbg_gnt, 1'b1); chk32("b2b_d1", dbg_rdata, 32'h22222222);
    chk1("b2b_v1", dbg_rvalid, 1'b1);
    nxt(); dbg_req = 0;
    smp(); chk1("b2b_v2", dbg_rvalid, 1'b1); chk32("b2b_d2", dbg_rdata, 32'h33333333);
    nxt();
    smp(); chk1("b2b_v3", dbg_rvalid, 1'b0);

    // Reset mid-operation: pending rvalid dropped, then counter restarts
    nxt();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    smp(); chk1("rstop_gnt", dbg_gnt, 1'b1);
    nxt(); dbg_req = 0;
    #2 rst = 1'b1;
    #1 chk1("rstop_rvalid_drop", dbg_rvalid, 1'b0);
    nxt(); rst = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      smp();
      nxt();
    end
    #2 rst = 1'b1;
    nxt(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp(); chk1("rstop_fresh_stall", cpu_stall, 1'b0);
      nxt();
    end
    smp(); chk1("rstop_force", cpu_stall, 1'b1);
    nxt();
    cpu_req = 0; dbg_req = 0;

    // Random traffic, DBG fields held until granted
    for (int c = 0; c < 3000; c++) begin
      nxt();
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_type  = 3'($urandom_range(0, 4));
      cpu_addr  = 32'($urandom_range(0, 127)) * 4;
      cpu_wdata = $urandom();
      if (!dbg_req || gnt_seen) begin
        dbg_req   = ($urandom_range(0, 2) != 0);
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_type  = 3'($urandom_range(0, 4));
        dbg_wdata = $urandom();
        r = $urandom_range(0, 7);
        if (r == 0) dbg_addr = DM_BYTES + 32'($urandom_range(0, 255)) * 4;
        else if (r == 1) dbg_addr = $urandom();
        else dbg_addr = 32'($urandom_range(0, 127)) * 4;
      end
    end
    nxt();
    cpu_req = 0; dbg_req = 0;
    smp();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
